// File: rtl/addsub_serial_alu.sv
// addsub_serial_alu
//   Multi-cycle add/subtract unit. It processes CHUNK bits per cycle, so one
//   WIDTH-bit operation takes N = WIDTH/CHUNK cycles. It supports four ops
//   (ADD, ADC, SUB, SBC), a carry-in, and reports carry, overflow, zero and
//   negative flags. Both sides use a valid/ready handshake.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operand set
//   BUSY  | adding one CHUNK-bit slice per cycle, LSB slice first
//   DONE  | out_valid=1, result and flags held until out_ready
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   operand handshake (op, a, b, c_in are sampled on accept)
//   out_valid/out_ready result handshake
//   op                  00 ADD, 01 ADC, 10 SUB, 11 SBC
//   sum, c_out          result mod 2^WIDTH; carry out of the MSB (1 = no borrow on SUB/SBC)
//   overflow            signed overflow
//   zero, negative      sum == 0; sum MSB
//
// WIDTH must be >= 2, and CHUNK must divide WIDTH.
module addsub_serial_alu #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  logic [CHUNK:0]   w_chunk;
  logic [WIDTH-1:0] w_a_next;
  logic             w_last;
  logic             w_ovf;

  assign w_chunk = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_last  = (r_cnt == CW'(N - 1));

  // Same-sign operands producing a result of the opposite sign. This is
  // equivalent to (carry into MSB) XOR (carry out of MSB). It is only
  // meaningful on the last slice, because that slice holds the MSBs.
  assign w_ovf = (r_a[CHUNK-1] == r_b[CHUNK-1]) && (w_chunk[CHUNK-1] != r_a[CHUNK-1]);

  // Each result slice is shifted into the top of r_a as the consumed A bits
  // leave the bottom. After N steps, r_a holds the full result.
  generate
    if (CHUNK == WIDTH) begin : g_full
      assign w_a_next = w_chunk[CHUNK-1:0];
    end else begin : g_part
      assign w_a_next = {w_chunk[CHUNK-1:0], r_a[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= op[1] ? ~b : b;
            // ADD: 0; SUB: 1 (two's complement); ADC/SBC: c_in.
            r_carry <= op[0] ? c_in : op[1];
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_a     <= w_a_next;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_chunk[CHUNK];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_a_next;
            r_c_out <= w_chunk[CHUNK];
            r_ovf   <= w_ovf;
            r_zero  <= (w_a_next == '0);
            r_neg   <= w_a_next[WIDTH-1];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign negative  = r_neg;

endmodule

// File: tb/tb_addsub_serial_alu.sv
module tb_addsub_serial_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [1:0] op;
  logic [7:0] a, b, sum;
  logic       c_in, c_out, overflow, zero, negative;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [1:0]  d_op;
  logic [15:0] d_a, d_b, d_sum;
  logic        d_c_in, d_c_out, d_overflow, d_zero, d_negative;

  int tests;
  int failed;

  addsub_serial_alu #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .overflow(overflow),
    .zero(zero), .negative(negative)
  );

  addsub_serial_alu #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .op(d_op), .a(d_a), .b(d_b), .c_in(d_c_in), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .sum(d_sum), .c_out(d_c_out), .overflow(d_overflow),
    .zero(d_zero), .negative(d_negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       neg;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operand set, scramble the inputs right after the accept edge,
  // and measure the latency to out_valid. Optionally release the result.
  task automatic run_op(input vec_t v, input int idx, input bit release_out);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", idx), {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b; c_in = v.cin;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~v.op; a = ~v.a; b = 8'h5A; c_in = ~v.cin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, 4);
    chk($sformatf("v%0d sum", idx), {24'b0, sum}, {24'b0, v.sum});
    chk($sformatf("v%0d c_out", idx), {31'b0, c_out}, {31'b0, v.cout});
    chk($sformatf("v%0d overflow", idx), {31'b0, overflow}, {31'b0, v.ovf});
    chk($sformatf("v%0d zero", idx), {31'b0, zero}, {31'b0, v.zero});
    chk($sformatf("v%0d negative", idx), {31'b0, negative}, {31'b0, v.neg});
    if (release_out) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk($sformatf("v%0d released", idx), {31'b0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    vec_t hv;
    int seen;
    int lat;
    tests = 0; failed = 0;
    in_valid = 0; out_ready = 0; op = 0; a = 0; b = 0; c_in = 0;
    d_in_valid = 0; d_out_ready = 0; d_op = 0; d_a = 0; d_b = 0; d_c_in = 0;

    //           op     a      b      cin   sum    co    ov    z     n
    vecs[0] = '{2'b10, 8'h01, 8'h04, 1'b0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'b10, 8'h81, 8'h05, 1'b0, 8'h7C, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2'b00, 8'h7F, 8'h41, 1'b0, 8'hC0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2'b00, 8'hFF, 8'h81, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'b11, 8'h05, 8'h05, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{2'b01, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{2'b01, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{2'b11, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{2'b00, 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst sum", {24'b0, sum}, 32'd0);
    chk("rst flags", {28'b0, c_out, overflow, zero, negative}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i], i, 1'b1);

    // DONE must hold its outputs while out_ready is low and must ignore new operands.
    hv = '{2'b00, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0};
    run_op(hv, 10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; a = 8'hE0 + 8'(i); b = 8'h11; op = 2'(i);
      @(posedge clk); #1;
      chk($sformatf("hold%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d in_ready", i), {31'b0, in_ready}, 32'd0);
      chk($sformatf("hold%0d sum", i), {24'b0, sum}, 32'h46);
      chk($sformatf("hold%0d flags", i), {28'b0, c_out, overflow, zero, negative}, 32'd0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("hold released", {31'b0, in_ready}, 32'd1);

    // A reset pulse mid-BUSY aborts the operation and clears the result registers.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; a = 8'h33; b = 8'h44; c_in = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    chk("abort in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort sum", {24'b0, sum}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort no out_valid", seen, 0);

    // WIDTH=16, CHUNK=4: SUB 0x8000 - 0x0001.
    @(negedge clk);
    d_in_valid = 1'b1; d_op = 2'b10; d_a = 16'h8000; d_b = 16'h0001; d_c_in = 1'b0;
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_a = 16'hFFFF; d_b = 16'hFFFF;
    lat = 0;
    while (!d_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16 latency", lat, 4);
    chk("w16 sum", {16'b0, d_sum}, 32'h7FFF);
    chk("w16 overflow", {31'b0, d_overflow}, 32'd1);
    chk("w16 c_out", {31'b0, d_c_out}, 32'd1);
    chk("w16 zn", {30'b0, d_zero, d_negative}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
